// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam int DIV_W_DEFAULT = 32;

  // Bits needed to count 0..w iterations inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on magnitudes.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W_DEFAULT
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;
  logic           w_fits;

  // Remainder stays below the divisor, so the WIDTH+1-bit trial's top bit is its sign.
  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, i_div};
  assign w_fits  = ~w_trial[WIDTH];

  assign o_rem = w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], w_fits};

endmodule

// File: rtl/restoring_div_seq.sv
// Multi-cycle signed/unsigned restoring divider with start/done handshake.
// Result is packed {remainder, quotient}; divide-by-zero is flagged with the result.
module restoring_div_seq
  import div_pkg::*;
#(
  parameter int WIDTH     = DIV_W_DEFAULT,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic                          i_signed_mode,
  input  logic [WIDTH-1:0]              i_dividend,
  input  logic [WIDTH-1:0]              i_divisor,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_div_by_zero,
  output logic [2*WIDTH-1:0]            o_result,
  output logic [cnt_width(WIDTH)-1:0]   o_iter_count
);

  localparam int CW = cnt_width(WIDTH);

  div_state_e       r_state, w_state_next;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs, r_dvd_raw;
  logic             r_neg_q, r_neg_r, r_zero, r_dbz;
  logic [CW-1:0]    r_iter;
  logic [2*WIDTH-1:0] r_result;

  logic             w_signed, w_dvd_neg, w_dvs_neg, w_zero_in, w_accept, w_last;
  logic [WIDTH-1:0] w_dvd_abs, w_dvs_abs, w_rem_step, w_quo_step, w_rem_fix, w_quo_fix;

  assign w_signed  = SIGNED_EN & i_signed_mode;
  assign w_dvd_neg = w_signed & i_dividend[WIDTH-1];
  assign w_dvs_neg = w_signed & i_divisor[WIDTH-1];
  // |MIN| wraps back to MIN, which is exactly 2^(WIDTH-1) read as unsigned.
  assign w_dvd_abs = w_dvd_neg ? -i_dividend : i_dividend;
  assign w_dvs_abs = w_dvs_neg ? -i_divisor : i_divisor;
  assign w_zero_in = (i_divisor == '0);
  assign w_accept  = (r_state == IDLE) && i_start;
  assign w_last    = (r_iter == CW'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_dvs),
    .o_rem (w_rem_step),
    .o_quo (w_quo_step)
  );

  assign w_quo_fix = r_neg_q ? -r_quo : r_quo;
  assign w_rem_fix = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // A zero divisor skips RUN but still passes FIX, where every final result is formed.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_next = w_zero_in ? FIX : RUN;
      RUN:     if (w_last) w_state_next = FIX;
      FIX:     w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state == RUN) || (r_state == FIX);
    o_done = (r_state == DONE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvs     <= '0;
      r_dvd_raw <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_zero    <= 1'b0;
      r_dbz     <= 1'b0;
      r_iter    <= '0;
      r_result  <= '0;
    end else begin
      if (w_accept) begin
        r_rem     <= '0;
        r_quo     <= w_dvd_abs;
        r_dvs     <= w_dvs_abs;
        r_dvd_raw <= i_dividend;
        r_neg_q   <= w_dvd_neg ^ w_dvs_neg;
        r_neg_r   <= w_dvd_neg;
        r_zero    <= w_zero_in;
        r_iter    <= '0;
      end
      if (r_state == RUN) begin
        r_rem  <= w_rem_step;
        r_quo  <= w_quo_step;
        r_iter <= r_iter + CW'(1);
      end
      // Result and flag only change here, so they hold across a new start.
      if (r_state == FIX) begin
        r_dbz    <= r_zero;
        r_result <= r_zero ? {r_dvd_raw, {WIDTH{1'b1}}} : {w_rem_fix, w_quo_fix};
      end
    end
  end

  assign o_result      = r_result;
  assign o_div_by_zero = r_dbz;
  assign o_iter_count  = r_iter;

endmodule

// File: tb/tb_restoring_div_seq.sv
// Randomised and directed bench for restoring_div_seq against an arithmetic reference model.
module tb_restoring_div_seq;

  localparam int W   = 32;
  localparam int CW  = $clog2(W + 1);
  localparam int LIM = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, sm = 1'b0;
  logic [W-1:0]  a = '0, b = '0;
  logic          busy, done, dbz;
  logic [2*W-1:0] res;
  logic [CW-1:0] iter;

  logic          start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]    a8 = '0, b8 = '0;
  logic          busy8, done8, dbz8;
  logic [15:0]   res8;
  logic [3:0]    iter8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  restoring_div_seq #(.WIDTH(W), .SIGNED_EN(1'b1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_signed_mode(sm),
    .i_dividend(a), .i_divisor(b), .o_busy(busy), .o_done(done),
    .o_div_by_zero(dbz), .o_result(res), .o_iter_count(iter)
  );

  restoring_div_seq #(.WIDTH(8), .SIGNED_EN(1'b1)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start8), .i_signed_mode(sm8),
    .i_dividend(a8), .i_divisor(b8), .o_busy(busy8), .o_done(done8),
    .o_div_by_zero(dbz8), .o_result(res8), .o_iter_count(iter8)
  );

  // Reference: plain integer division, truncating toward zero, remainder follows dividend.
  function automatic void model(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sx, sy, lq, lr;
    z = (y == 0);
    if (z) begin
      q = '1;
      r = x;
    end else if (m) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      lq = sx / sy;
      lr = sx % sy;
      q  = lq[W-1:0];
      r  = lr[W-1:0];
    end else begin
      q = x / y;
      r = x % y;
    end
  endfunction

  task automatic run_op(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat, output logic [2*W-1:0] r_out, output logic z_out,
                        output logic extra_done);
    @(posedge clk);
    @(negedge clk);
    sm = m; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < LIM) begin
      @(posedge clk); #1;
      lat++;
    end
    r_out = res;
    z_out = dbz;
    @(posedge clk); #1;
    extra_done = done;
    $display("op sm=%0b %h / %h -> res=%h dbz=%0b lat=%0d", m, x, y, r_out, z_out, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (dbz !== 1'b0) begin n_bad++; $display("FAIL reset_dbz: got %b expected 0", dbz); end
    n_cmp++; if (res !== '0) begin n_bad++; $display("FAIL reset_result: got %h expected 0", res); end
    n_cmp++; if (iter !== '0) begin n_bad++; $display("FAIL reset_iter: got %0d expected 0", iter); end
    @(negedge clk);
    rst = 1'b0;
    $display("reset released");
  endtask

  typedef struct {
    logic         m;
    logic [W-1:0] x, y, q, r;
    logic         z;
    int           lat;
  } vec_t;

  task automatic test_directed();
    vec_t vecs[8];
    int lat;
    logic [2*W-1:0] r_out;
    logic z_out, xd;
    vecs[0] = '{1'b0, 32'd10,         32'd3,         32'd3,         32'd1,         1'b0, 34};
    vecs[1] = '{1'b0, 32'd1,          32'hFFFFFFFF,  32'd0,         32'd1,         1'b0, 34};
    vecs[2] = '{1'b1, 32'd1,          32'hFFFFFFFF,  32'hFFFFFFFF,  32'd0,         1'b0, 34};
    vecs[3] = '{1'b1, 32'hFFFFFFF9,   32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0, 34};
    vecs[4] = '{1'b1, 32'd7,          32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         1'b0, 34};
    vecs[5] = '{1'b0, 32'd97,         32'd0,         32'hFFFFFFFF,  32'd97,        1'b1, 2};
    vecs[6] = '{1'b0, 32'd30480,      32'd11,        32'd2770,      32'd10,        1'b0, 34};
    vecs[7] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0, 34};
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].m, vecs[i].x, vecs[i].y, lat, r_out, z_out, xd);
      n_cmp++; if (r_out !== {vecs[i].r, vecs[i].q}) begin n_bad++; $display("FAIL dir%0d_result: got %h expected %h", i, r_out, {vecs[i].r, vecs[i].q}); end
      n_cmp++; if (z_out !== vecs[i].z) begin n_bad++; $display("FAIL dir%0d_dbz: got %b expected %b", i, z_out, vecs[i].z); end
      n_cmp++; if (lat !== vecs[i].lat) begin n_bad++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, vecs[i].lat); end
      n_cmp++; if (xd !== 1'b0) begin n_bad++; $display("FAIL dir%0d_done_width: got %b expected 0", i, xd); end
    end
  endtask

  task automatic test_ignored_start();
    int cyc;
    @(posedge clk);
    @(negedge clk);
    sm = 1'b0; a = 32'd68; b = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 5) begin @(posedge clk); #1; cyc++; end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ign_busy: got %b expected 1", busy); end
    n_cmp++; if (iter !== CW'(4)) begin n_bad++; $display("FAIL ign_iter: got %0d expected 4", iter); end
    @(negedge clk);
    a = 32'd80; b = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc++;
    while (done !== 1'b1 && cyc < LIM) begin @(posedge clk); #1; cyc++; end
    $display("op ignored-start 68/2 -> res=%h lat=%0d", res, cyc);
    n_cmp++; if (cyc !== 34) begin n_bad++; $display("FAIL ign_latency: got %0d expected 34", cyc); end
    n_cmp++; if (res !== {32'd0, 32'd34}) begin n_bad++; $display("FAIL ign_result: got %h expected %h", res, {32'd0, 32'd34}); end
    n_cmp++; if (iter !== CW'(W)) begin n_bad++; $display("FAIL ign_iter_final: got %0d expected %0d", iter, W); end
  endtask

  task automatic test_hold_start();
    int cyc, first, second;
    first = 0; second = 0;
    @(posedge clk);
    @(negedge clk);
    sm = 1'b0; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    a = 32'd5; b = 32'd3;
    while (second == 0 && cyc < 150) begin
      @(posedge clk); #1;
      cyc++;
      if (done === 1'b1) begin
        if (first == 0) begin
          first = cyc;
          n_cmp++; if (res !== {32'd6, 32'd142}) begin n_bad++; $display("FAIL hold_result1: got %h expected %h", res, {32'd6, 32'd142}); end
        end else begin
          second = cyc;
          start = 1'b0;
        end
      end
      if (cyc == 40) begin
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL hold_busy2: got %b expected 1", busy); end
        n_cmp++; if (res !== {32'd6, 32'd142}) begin n_bad++; $display("FAIL hold_result_kept: got %h expected %h", res, {32'd6, 32'd142}); end
      end
    end
    start = 1'b0;
    $display("op held-start 1000/7 then 5/3 -> done at %0d and %0d res=%h", first, second, res);
    n_cmp++; if (first !== 34) begin n_bad++; $display("FAIL hold_done1_cycle: got %0d expected 34", first); end
    n_cmp++; if (second !== 69) begin n_bad++; $display("FAIL hold_done2_cycle: got %0d expected 69", second); end
    n_cmp++; if (res !== {32'd2, 32'd1}) begin n_bad++; $display("FAIL hold_result2: got %h expected %h", res, {32'd2, 32'd1}); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc, seen;
    @(negedge clk);
    sm = 1'b0; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin @(posedge clk); #1; cyc++; end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    n_cmp++; if (res !== '0) begin n_bad++; $display("FAIL rstmid_result: got %h expected 0", res); end
    n_cmp++; if (iter !== '0) begin n_bad++; $display("FAIL rstmid_iter: got %0d expected 0", iter); end
    n_cmp++; if (dbz !== 1'b0) begin n_bad++; $display("FAIL rstmid_dbz: got %b expected 0", dbz); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    $display("op reset at cycle 10 of 1000/3 -> done pulses afterwards=%0d", seen);
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d expected 0", seen); end
  endtask

  task automatic test_random();
    int lat, sel;
    logic m, z_out, xd, ez;
    logic [W-1:0] x, y, eq, er;
    logic [2*W-1:0] r_out;
    for (int i = 0; i < 60; i++) begin
      m   = 1'($urandom_range(0, 1));
      x   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       y = '0;
        1:       begin x = 32'h80000000; y = '1; end
        2:       y = W'($urandom_range(1, 15));
        3:       begin x = W'($urandom_range(0, 100)); y = $urandom; end
        default: y = $urandom;
      endcase
      model(m, x, y, eq, er, ez);
      run_op(m, x, y, lat, r_out, z_out, xd);
      n_cmp++; if (r_out !== {er, eq}) begin n_bad++; $display("FAIL rnd%0d_result: got %h expected %h", i, r_out, {er, eq}); end
      n_cmp++; if (z_out !== ez) begin n_bad++; $display("FAIL rnd%0d_dbz: got %b expected %b", i, z_out, ez); end
      n_cmp++; if (lat !== (ez ? 2 : W + 2)) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, ez ? 2 : W + 2); end
      n_cmp++; if (xd !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_done_width: got %b expected 0", i, xd); end
    end
  endtask

  task automatic test_width8();
    logic [7:0] xs[2], ys[2], qs[2], rs[2];
    logic       ms[2];
    int cyc;
    xs[0] = 8'd200; ys[0] = 8'd7;  qs[0] = 8'd28;  rs[0] = 8'd4;  ms[0] = 1'b0;
    xs[1] = 8'h9C;  ys[1] = 8'd7;  qs[1] = 8'hF2;  rs[1] = 8'hFE; ms[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      sm8 = ms[i]; a8 = xs[i]; b8 = ys[i]; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      cyc = 1;
      while (done8 !== 1'b1 && cyc < LIM) begin @(posedge clk); #1; cyc++; end
      $display("op w8 sm=%0b %h / %h -> res=%h lat=%0d", ms[i], xs[i], ys[i], res8, cyc);
      n_cmp++; if (cyc !== 10) begin n_bad++; $display("FAIL w8_%0d_latency: got %0d expected 10", i, cyc); end
      n_cmp++; if (res8 !== {rs[i], qs[i]}) begin n_bad++; $display("FAIL w8_%0d_result: got %h expected %h", i, res8, {rs[i], qs[i]}); end
      n_cmp++; if (dbz8 !== 1'b0) begin n_bad++; $display("FAIL w8_%0d_dbz: got %b expected 0", i, dbz8); end
      @(posedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignored_start();
    test_hold_start();
    test_reset_mid();
    test_random();
    test_width8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
